csr_arbiter: RTL and testbench
==============================

# csr_arbiter

- Shares the single CSR register-bank port between the I2C slave and NUM_REQ internal requesters that use a req/ack handshake.
- The I2C side is passive:
  - Its address and write strobe are passed through by default.
  - It gets read data from a shadow register, so it never stalls.
- Internal requesters steal one bus cycle per access.
- Any I2C write that collides with a stolen cycle is buffered and replayed on the next cycle.

## Interface

Parameters:

- NUM_REQ, 2, number of handshake requesters (1..4)
- ADDR_W, 8, CSR address width
- DATA_W, 8, CSR data width

Ports:

- clk  in  1  system clock; everything is on its rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- i2c_a  in  ADDR_W  I2C slave index pointer
- i2c_we  in  1  I2C write strobe, single-cycle
- i2c_do  in  DATA_W  I2C write data
- i2c_di  out  DATA_W  read data to I2C slave (shadow register)
- req  in  NUM_REQ  per-requester access request, level
- req_a  in  NUM_REQ*ADDR_W  per-requester address, packed, slot i at [i*ADDR_W +: ADDR_W]
- req_we  in  NUM_REQ  per-requester write (1) / read (0)
- req_wdata  in  NUM_REQ*DATA_W  per-requester write data, packed
- req_ack  out  NUM_REQ  one-cycle completion pulse, one-hot
- req_rdata  out  DATA_W  read data; valid while req_ack is high
- csr_a  out  ADDR_W  bank address
- csr_we  out  1  bank write strobe
- csr_do  out  DATA_W  bank write data
- csr_di  in  DATA_W  bank read data, combinational from csr_a

## Operation

States:

- IDLE: bus owned by I2C.
  - csr_a = i2c_a, csr_do = i2c_do, csr_we = i2c_we.
  - i2c_di <= csr_di every cycle.
  - If i2c_we = 0 and any req bit is set: latch the winner index, go to ACCESS.
  - If i2c_we = 1: stay in IDLE; arbitration is retried next cycle.
- ACCESS: bus owned by the winner w.
  - csr_a = req_a[w], csr_we = req_we[w], csr_do = req_wdata[w].
  - req_rdata <= csr_di.
  - i2c_di is held.
  - If i2c_we = 1 this cycle: latch i2c_a and i2c_do into the pending buffer and set pend.
  - Always go to RECOVER.
- RECOVER:
  - req_ack[w] = 1.
  - If pend: drive the buffered address and data with csr_we = 1, clear pend, and hold i2c_di.
  - Else: bus as in IDLE, including i2c_we passthrough and i2c_di refresh.
  - Always go to IDLE.

Requesters:

- Hold req, address and data stable until ack.
- Drop req in the cycle after ack; otherwise a new access starts.

Arbitration:

- A round-robin pointer advances to the slot after w on every grant.
- Selection is the lowest set req index at or after the pointer, wrapping modulo NUM_REQ.

Bounds and guarantees:

- I2C strobes are at least 3 cycles apart, so the pending buffer never overflows.
- I2C stalls never occur.
- Worst-case requester wait is NUM_REQ*3 cycles plus one cycle per concurrent i2c_we.

Reset:

- State = IDLE, pointer = 0, pend = 0.
- i2c_di = 0, req_rdata = 0, req_ack = 0.
- csr_we = i2c_we passthrough; with i2c_we low during reset, csr_we = 0.
- Reset asserted mid-ACCESS aborts the access: no ack is issued and the pending write is discarded.

## Timing

- Handshake latency: req seen high in IDLE at cycle 0 → bus access at cycle 1 → req_ack and req_rdata at cycle 2 → back in IDLE at cycle 3.
- The I2C path is zero-latency for writes in IDLE.
- A colliding I2C write lands exactly one cycle late, in RECOVER.
- i2c_di:
  - Lags csr_di by 1 cycle and is frozen for 2 cycles per stolen access.
  - The I2C slave samples many cycles after its address changes, so the frozen value is acceptable.
- csr_a, csr_we and csr_do are combinational muxes of registered state and port inputs.
- req_ack and req_rdata are registered/decoded from state only.

## Configuration

- CSR_ARB_ROUND_ROBIN_EN defined: round-robin pointer as described above.
- CSR_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest req index always wins; the pointer register is removed.

## Structure

- Shared package csr_pkg holds:
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, RECOVER=2'd2)
  - CSR_ADDR_W and CSR_DATA_W
- One sub-module, rr_arbiter: req vector plus pointer in, one-hot grant and index out.
  - Under the macro-off build it degenerates to a priority encoder.

## Test plan

- I2C write only: i2c_a=0x10, i2c_do=0x5A, i2c_we pulse in IDLE → csr_we=1, csr_a=0x10, csr_do=0x5A in the same cycle.
- Requester 1 reads 0x22, bank returns 0xC3 → req_ack[1] 2 cycles after req, req_rdata=0xC3; i2c_di unchanged during ACCESS and RECOVER.
- Collision: req0 writes 0x30←0x11 while i2c_we (0x31←0x77) pulses in the ACCESS cycle → 0x30 is written in ACCESS, 0x31←0x77 is written in RECOVER; both values are read back.
- req0 and req1 are held continuously with round-robin enabled → grants alternate 0, 1, 0, 1; with the macro off, grants are 0, 0, 0.
- i2c_we coincides with req in IDLE → I2C write first, ACCESS starts one cycle later.
- rst asserted during ACCESS → no req_ack, state IDLE, pend=0, i2c_di=0 the cycle after assertion.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the CSR bank arbiter: state encoding and default bus widths.
// Latency: none (package only).
// Backpressure: none (package only).
package csr_pkg;

  localparam int CSR_ADDR_W = 8;
  localparam int CSR_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  // Index width for an n-entry requester set; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Requester selector: picks the lowest set req index at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is taken.
//
// Ports: req (request vector), ptr (search start slot), gnt (one-hot grant),
//        idx (binary index of the granted slot, 0 when nothing is requested).
// Build option CSR_ARB_ROUND_ROBIN_EN: when undefined, ptr is ignored and this
// becomes a plain lowest-index priority encoder.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

`ifdef CSR_ARB_ROUND_ROBIN_EN
  always_comb begin
    int   j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    // Walk the slots starting at ptr; the first requesting one wins.
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/csr_arbiter.sv
// Shares one CSR bank port between a passive I2C slave and NUM_REQ req/ack requesters.
// Latency: I2C writes pass through in 0 cycles (1 when colliding); requester ack 2 cycles after req.
// Backpressure: I2C never stalls; requesters wait on req_ack, one stolen bus cycle per access.
//
// Ports: clk, rst (async, active-low); I2C side i2c_a/i2c_we/i2c_do in, i2c_di out
//        (shadow register); requester side req/req_a/req_we/req_wdata in,
//        req_ack/req_rdata out; bank side csr_a/csr_we/csr_do out, csr_di in.
// Build option CSR_ARB_ROUND_ROBIN_EN: round-robin grant pointer; undefined gives
// fixed priority (lowest index wins) with no pointer register.
module csr_arbiter
  import csr_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = CSR_ADDR_W,
  parameter int DATA_W  = CSR_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         i2c_a,
  input  logic                      i2c_we,
  input  logic [DATA_W-1:0]         i2c_do,
  output logic [DATA_W-1:0]         i2c_di,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_a,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [ADDR_W-1:0]         csr_a,
  output logic                      csr_we,
  output logic [DATA_W-1:0]         csr_do,
  input  logic [DATA_W-1:0]         csr_di
);

  localparam int IDX_W = idx_w(NUM_REQ);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               start;
  logic               pend;
  logic [ADDR_W-1:0]  pend_a;
  logic [DATA_W-1:0]  pend_d;
  logic [ADDR_W-1:0]  win_a;
  logic [DATA_W-1:0]  win_d;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // An I2C write always owns the IDLE cycle; arbitration simply retries next cycle.
  assign start = (state == IDLE) && !i2c_we && (|gnt);

`ifdef CSR_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (start) begin
      if (int'(gnt_idx) == NUM_REQ - 1) ptr <= '0;
      else                              ptr <= gnt_idx + IDX_W'(1);
    end
  end
`else
  assign ptr = '0;
`endif

  always_comb begin
    win_a = req_a[int'(win)*ADDR_W +: ADDR_W];
    win_d = req_wdata[int'(win)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    csr_a     = i2c_a;
    csr_do    = i2c_do;
    csr_we    = i2c_we;
    req_ack   = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCESS;
      end
      ACCESS: begin
        csr_a     = win_a;
        csr_do    = win_d;
        csr_we    = req_we[win];
        state_nxt = RECOVER;
      end
      RECOVER: begin
        req_ack[win] = 1'b1;
        // Replay the I2C write that lost the bus during ACCESS.
        if (pend) begin
          csr_a  = pend_a;
          csr_do = pend_d;
          csr_we = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win       <= '0;
      pend      <= 1'b0;
      pend_a    <= '0;
      pend_d    <= '0;
      i2c_di    <= '0;
      req_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          i2c_di <= csr_di;
          if (start) win <= gnt_idx;
        end
        ACCESS: begin
          // i2c_di holds: the bank is showing the requester's address now.
          req_rdata <= csr_di;
          if (i2c_we) begin
            pend   <= 1'b1;
            pend_a <= i2c_a;
            pend_d <= i2c_do;
          end
        end
        RECOVER: begin
          if (pend) pend   <= 1'b0;
          else      i2c_di <= csr_di;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_arbiter.sv
// Self-checking bench for csr_arbiter with a behavioural CSR bank.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_csr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i2c_a;
  logic        i2c_we;
  logic [7:0]  i2c_do;
  logic [7:0]  i2c_di;
  logic [1:0]  req;
  logic [15:0] req_a;
  logic [1:0]  req_we;
  logic [15:0] req_wdata;
  logic [1:0]  req_ack;
  logic [7:0]  req_rdata;
  logic [7:0]  csr_a;
  logic        csr_we;
  logic [7:0]  csr_do;
  logic [7:0]  csr_di;

  always #5 clk = ~clk;

  csr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i2c_a     (i2c_a),
    .i2c_we    (i2c_we),
    .i2c_do    (i2c_do),
    .i2c_di    (i2c_di),
    .req       (req),
    .req_a     (req_a),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .req_rdata (req_rdata),
    .csr_a     (csr_a),
    .csr_we    (csr_we),
    .csr_do    (csr_do),
    .csr_di    (csr_di)
  );

  // Behavioural register bank: combinational read, clocked write.
  logic [7:0] mem [0:255];
  always @(posedge clk) if (csr_we) mem[csr_a] <= csr_do;
  assign csr_di = mem[csr_a];

  typedef struct {
    int         idx;
    logic [7:0] rd;
    bit         chk_rd;
    int         cyc;
  } sb_t;

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic       we;
    logic [7:0] wd;
    logic [7:0] exp_rd;
  } vec_t;

  sb_t sb[$];
  int  n_chk  = 0;
  int  n_pass = 0;
  int  cyc    = 0;
  bit  seen   = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    else             n_pass++;
  endfunction

  // Negedge of the current cycle: retire any ack against the scoreboard.
  task automatic mid();
    sb_t e;
    @(negedge clk);
    seen = 1'b1;
    if (req_ack !== 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(req_ack), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_onehot", 32'(req_ack), 32'(1 << e.idx));
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        if (e.chk_rd) chk("ack_rdata", 32'(req_rdata), 32'(e.rd));
      end
    end
  endtask

  task automatic tick();
    if (!seen) mid();
    @(posedge clk);
    #1;
    seen = 1'b0;
    cyc++;
  endtask

  task automatic i2c_wr(input logic [7:0] a, input logic [7:0] d);
    i2c_a = a; i2c_do = d; i2c_we = 1'b1;
    mid();
    chk("i2c_pass_we", 32'(csr_we), 32'd1);
    chk("i2c_pass_a", 32'(csr_a), 32'(a));
    chk("i2c_pass_do", 32'(csr_do), 32'(d));
    tick();
    i2c_we = 1'b0;
    tick();
    tick();
  endtask

  // Single requester access started in IDLE; i2c_a must point at 0x10 (0x5A).
  task automatic access(input int idx, input logic [7:0] a, input logic we,
                        input logic [7:0] wd, input logic [7:0] exp_rd);
    req[idx] = 1'b1;
    req_a[idx*8 +: 8] = a;
    req_we[idx] = we;
    req_wdata[idx*8 +: 8] = wd;
    sb.push_back('{idx, exp_rd, !we, cyc + 2});
    tick();
    mid();
    chk("acc_csr_a", 32'(csr_a), 32'(a));
    chk("acc_csr_we", 32'(csr_we), 32'(we));
    if (we) chk("acc_csr_do", 32'(csr_do), 32'(wd));
    tick();
    mid();
    chk("rec_i2c_di_hold", 32'(i2c_di), 32'h5A);
    tick();
    req[idx] = 1'b0;
    tick();
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1, 8'h22, 1'b0, 8'h00, 8'hC3};
    vecs[1] = '{0, 8'h40, 1'b1, 8'hA5, 8'h00};
    vecs[2] = '{0, 8'h40, 1'b0, 8'h00, 8'hA5};
    vecs[3] = '{1, 8'h41, 1'b1, 8'h3C, 8'h00};
    vecs[4] = '{1, 8'h41, 1'b0, 8'h00, 8'h3C};
    vecs[5] = '{0, 8'hFF, 1'b0, 8'h00, 8'h81};
    vecs[6] = '{1, 8'h00, 1'b0, 8'h00, 8'h7E};

    rst = 1'b0; i2c_a = '0; i2c_we = 1'b0; i2c_do = '0;
    req = '0; req_a = '0; req_we = '0; req_wdata = '0;

    // Reset state.
    mid();
    chk("rst_i2c_di", 32'(i2c_di), 32'd0);
    chk("rst_req_rdata", 32'(req_rdata), 32'd0);
    chk("rst_req_ack", 32'(req_ack), 32'd0);
    chk("rst_csr_we", 32'(csr_we), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Preload the bank through the I2C passthrough path.
    i2c_wr(8'h10, 8'h5A);
    i2c_wr(8'h22, 8'hC3);
    i2c_wr(8'hFF, 8'h81);
    i2c_wr(8'h00, 8'h7E);
    i2c_wr(8'h50, 8'hAA);
    i2c_wr(8'h51, 8'hBB);
    i2c_wr(8'h60, 8'h66);
    i2c_a = 8'h10;
    tick();
    mid();
    chk("i2c_di_refresh", 32'(i2c_di), 32'h5A);
    tick();

    // Table of single-requester accesses.
    for (int i = 0; i < 7; i++)
      access(vecs[i].idx, vecs[i].a, vecs[i].we, vecs[i].wd, vecs[i].exp_rd);

    // Collision: I2C write during ACCESS is replayed in RECOVER.
    req[0] = 1'b1; req_a[7:0] = 8'h30; req_we[0] = 1'b1; req_wdata[7:0] = 8'h11;
    sb.push_back('{0, 8'h00, 1'b0, cyc + 2});
    tick();
    i2c_we = 1'b1; i2c_a = 8'h31; i2c_do = 8'h77;
    mid();
    chk("col_acc_a", 32'(csr_a), 32'h30);
    chk("col_acc_we", 32'(csr_we), 32'd1);
    chk("col_acc_do", 32'(csr_do), 32'h11);
    tick();
    i2c_we = 1'b0; i2c_a = 8'h10;
    mid();
    chk("col_rec_a", 32'(csr_a), 32'h31);
    chk("col_rec_we", 32'(csr_we), 32'd1);
    chk("col_rec_do", 32'(csr_do), 32'h77);
    tick();
    req[0] = 1'b0;
    mid();
    chk("col_after_we", 32'(csr_we), 32'd0);
    tick();
    tick();
    access(1, 8'h30, 1'b0, 8'h00, 8'h11);
    access(0, 8'h31, 1'b0, 8'h00, 8'h77);

    // I2C write coinciding with req in IDLE: write first, ACCESS one cycle later.
    req[0] = 1'b1; req_a[7:0] = 8'h60; req_we[0] = 1'b0;
    i2c_we = 1'b1; i2c_a = 8'h61; i2c_do = 8'h99;
    sb.push_back('{0, 8'h66, 1'b1, cyc + 3});
    mid();
    chk("coin_i2c_we", 32'(csr_we), 32'd1);
    chk("coin_i2c_a", 32'(csr_a), 32'h61);
    tick();
    i2c_we = 1'b0; i2c_a = 8'h10;
    mid();
    chk("coin_still_idle_a", 32'(csr_a), 32'h10);
    tick();
    mid();
    chk("coin_access_a", 32'(csr_a), 32'h60);
    tick();
    tick();
    req[0] = 1'b0;
    tick();
    tick();
    access(1, 8'h61, 1'b0, 8'h00, 8'h99);

    // Reset asserted mid-ACCESS aborts the access.
    req[1] = 1'b1; req_a[15:8] = 8'h70; req_we[1] = 1'b1; req_wdata[15:8] = 8'h12;
    tick();
    i2c_we = 1'b1; i2c_a = 8'h71; i2c_do = 8'h44;
    #2 rst = 1'b0;
    mid();
    chk("abort_i2c_di", 32'(i2c_di), 32'd0);
    chk("abort_req_rdata", 32'(req_rdata), 32'd0);
    chk("abort_idle_a", 32'(csr_a), 32'h71);
    tick();
    rst = 1'b1; i2c_we = 1'b0; i2c_a = 8'h10; req = '0;
    mid();
    chk("abort_no_replay_we", 32'(csr_we), 32'd0);
    chk("abort_no_ack", 32'(req_ack), 32'd0);
    tick();
    tick();

    // Both requesters held continuously, pointer fresh from reset.
    req = 2'b11; req_a = {8'h51, 8'h50}; req_we = 2'b00;
    for (int g = 0; g < 4; g++) begin
`ifdef CSR_ARB_ROUND_ROBIN_EN
      if (g % 2 == 0) sb.push_back('{0, 8'hAA, 1'b1, cyc + 2 + 3*g});
      else            sb.push_back('{1, 8'hBB, 1'b1, cyc + 2 + 3*g});
`else
      sb.push_back('{0, 8'hAA, 1'b1, cyc + 2 + 3*g});
`endif
    end
    for (int c = 0; c < 12; c++) tick();
    req = 2'b00;
    tick();
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
